// File: rtl/exp_avg_pkg.sv
// Shared constants, sequencer state type and width helper for the exponential-average bank.
package exp_avg_pkg;

  localparam int unsigned TICK_W_FULL = 22;
  localparam int unsigned TICK_W_FAST = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_e;

  function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned shift);
    return data_w + shift;
  endfunction

endpackage

// File: rtl/exp_avg_tick.sv
// Free-running periodic sample timer; tick_o is high for the one cycle the counter holds all-ones.
module exp_avg_tick
  import exp_avg_pkg::*;
#(
  parameter int unsigned FAST_SIM = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int unsigned TICK_W = (FAST_SIM != 0) ? TICK_W_FAST : TICK_W_FULL;
  localparam logic [TICK_W-1:0] PRE_WRAP = {{(TICK_W-1){1'b1}}, 1'b0};

  logic [TICK_W-1:0] cnt_q;
  logic              tick_q;

  // Flag is registered one count early so it lines up with the all-ones value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_q + TICK_W'(1);
      tick_q <= (cnt_q == PRE_WRAP);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/exp_avg_bank.sv
// Multi-channel exponential averager with round-robin shared update datapath.
// Optional sticky overrun flags are built when EXP_AVG_OVERRUN_EN is defined.
module exp_avg_bank
  import exp_avg_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned SHIFT    = 2,
  parameter int unsigned FAST_SIM = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] smpl_in,
  input  logic [NUM_CH-1:0]        mode,
  input  logic [NUM_CH-1:0]        strobe,
  input  logic [NUM_CH-1:0]        seed,
  input  logic                     ovr_clr,
  output logic [NUM_CH*DATA_W-1:0] avg_out,
  output logic [NUM_CH-1:0]        avg_vld,
  output logic [NUM_CH-1:0]        overrun
);

  localparam int unsigned ACC_W  = acc_w(DATA_W, SHIFT);
  localparam int unsigned PROD_W = ACC_W + SHIFT;
  localparam int unsigned CH_W   = $clog2(NUM_CH);

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   pend_q, pend_d;
  logic [NUM_CH-1:0]   seedf_q, seedf_d;
  logic [NUM_CH-1:0]   vld_q, vld_d;
  logic [CH_W-1:0]     rr_q, rr_d;
  logic [ACC_W-1:0]    acc_q [NUM_CH];

  logic                tick;
  logic [NUM_CH-1:0]   trig;
  logic [CH_W-1:0]     sel;
  logic                found;
  logic                svc;
  logic [DATA_W-1:0]   samp;
  logic [PROD_W-1:0]   prod;
  logic [ACC_W-1:0]    acc_next;

  exp_avg_tick #(
    .FAST_SIM (FAST_SIM)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  assign trig = ({NUM_CH{tick}} & ~mode) | (strobe & mode) | seed;

  // First pending channel at or after the round-robin pointer.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && pend_q[CH_W'(idx)]) begin
        found = 1'b1;
        sel   = CH_W'(idx);
      end
    end
  end

  assign svc = (state_q == UPDATE) && found;

  // Shared update: acc*(2^SHIFT-1) formed as (acc<<SHIFT)-acc in a widened product.
  always_comb begin
    samp     = smpl_in[32'(sel)*DATA_W +: DATA_W];
    prod     = (PROD_W'(acc_q[sel]) << SHIFT) - PROD_W'(acc_q[sel]);
    acc_next = seedf_q[sel] ? (ACC_W'(samp) << SHIFT)
                            : ACC_W'(samp) + ACC_W'(prod >> SHIFT);
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    seedf_d = seedf_q;
    rr_d    = rr_q;
    vld_d   = '0;
    if (svc) begin
      pend_d[sel]  = 1'b0;
      seedf_d[sel] = 1'b0;
      vld_d[sel]   = 1'b1;
      rr_d         = (32'(sel) == NUM_CH - 1) ? '0 : sel + CH_W'(1);
    end
    pend_d  = pend_d | trig;
    seedf_d = seedf_d | seed;
    unique case (state_q)
      IDLE:    if (|pend_d)  state_d = UPDATE;
      UPDATE:  if (~|pend_d) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      seedf_q <= '0;
      vld_q   <= '0;
      rr_q    <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
    end else begin
      pend_q  <= pend_d;
      seedf_q <= seedf_d;
      vld_q   <= vld_d;
      rr_q    <= rr_d;
      if (svc) acc_q[sel] <= acc_next;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign avg_out[g*DATA_W +: DATA_W] = acc_q[g][ACC_W-1:SHIFT];
  end

  assign avg_vld = vld_q;

`ifdef EXP_AVG_OVERRUN_EN
  logic [NUM_CH-1:0] ovr_q;
  logic [NUM_CH-1:0] ovr_set;

  // Trigger lost to an already-pending channel that is not being serviced now.
  assign ovr_set = trig & pend_q & ~vld_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovr_q <= '0;
    else        ovr_q <= (ovr_clr ? '0 : ovr_q) | ovr_set;
  end

  assign overrun = ovr_q;
`else
  logic unused_ovr_clr;
  assign unused_ovr_clr = ovr_clr;
  assign overrun        = '0;
`endif

endmodule

// File: doc/exp_avg_bank.md
# exp_avg_bank

Parametrised multi-channel exponential-average conditioner for the eBike sensor front end. It generalises the fixed current and torque averagers to NUM_CH channels of configurable width and smoothing window. Each channel triggers from a shared periodic sample timer or from its own event strobe (e.g. cadence rise). A round-robin sequencer services all channels through one shared update datapath.

## Interface
- NUM_CH, 4: number of channels (2..8)
- DATA_W, 12: sample and average width
- SHIFT, 2: smoothing exponent; weight (2^SHIFT-1)/2^SHIFT; accumulator width ACC_W = DATA_W+SHIFT
- FAST_SIM, 1: periodic tick every 2^16 clocks if 1, every 2^22 clocks if 0
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active low; one clock, no other reset
- smpl_in  in  NUM_CH*DATA_W  raw samples, channel i at [i*DATA_W +: DATA_W]
- mode  in  NUM_CH  per channel: 0 = periodic tick trigger, 1 = strobe trigger
- strobe  in  NUM_CH  single-cycle event triggers (used only when mode[i]=1)
- seed  in  NUM_CH  single-cycle reseed request
- ovr_clr  in  1  clears all overrun flags
- avg_out  out  NUM_CH*DATA_W  averages, accumulator bits [ACC_W-1:SHIFT]
- avg_vld  out  NUM_CH  one-cycle pulse when avg_out channel i changes
- overrun  out  NUM_CH  sticky lost-trigger flags

## Operation
- Trigger for channel i in cycle n: (tick & !mode[i]) | (strobe[i] & mode[i]) | seed[i]. It sets pend[i], visible in n+1. seed[i] also sets seedf[i].
- Sequencer FSM has two states:
  - IDLE: no pend bit set.
  - UPDATE: at least one pend bit set.
  - IDLE->UPDATE when any pend bit is set. UPDATE->IDLE when the last pend bit clears and no new trigger arrives.
- In UPDATE, each cycle selects the first pending channel at or after pointer rr, wrapping NUM_CH-1 -> 0. The selected channel is updated at that clock edge, its pend bit is cleared, and rr becomes sel+1 mod NUM_CH.
- Normal update, with s = smpl_in channel sel sampled in the service cycle (not the trigger cycle): acc_next = s + ((acc*(2^SHIFT-1)) >> SHIFT), floor. The result fits ACC_W with no saturation needed.
- Seed update (seedf set): acc_next = s << SHIFT, so the average equals s immediately. seedf is then cleared. Seed wins over a normal trigger pending on the same channel.
- New trigger on the channel serviced in the same cycle: pend stays set, and the channel is serviced again on its next round-robin turn.
- New trigger on a channel whose pend is already set and which is not being serviced: the trigger is coalesced and overrun[i] sets.
- ovr_clr clears all overrun flags. If a set and ovr_clr coincide, the set wins.
- Periodic tick counter free-runs, wraps, and pulses tick for one cycle on its all-ones value.

## Timing
- Reset values: acc, pend, seedf, rr, tick counter, avg_out, avg_vld and overrun are all 0. FSM is in IDLE.
- Reset asserted mid-operation drops all pending work. No update completes after rst_n falls.
- Minimum latency: trigger in n -> acc written at end of n+1 -> avg_out updated and avg_vld[i] high in n+2.
- Worst-case latency: n+1+NUM_CH cycles.
- avg_vld is registered, never high for two channels in the same cycle, and held low in IDLE.
- Sustained throughput: one channel update per clock.

## Configuration
- EXP_AVG_OVERRUN_EN defined: overrun flags and ovr_clr behave as above.
- Not defined: overrun is tied to 0, ovr_clr is ignored, and no flag flops are built. Coalescing behaviour is unchanged.

## Structure
- Package exp_avg_pkg holds:
  - tick width constants TICK_W_FULL=22 and TICK_W_FAST=16
  - the FSM state enum (IDLE, UPDATE)
  - function acc_w(DATA_W, SHIFT)
- Sub-module exp_avg_tick: periodic counter with FAST_SIM parameter, output tick.
- Round-robin select, the shared update datapath and the accumulator array live in exp_avg_bank.

## Test plan
All scenarios use NUM_CH=4, DATA_W=12, SHIFT=2, FAST_SIM=1.
- Reset check: assert rst_n low mid-run -> all outputs 0 immediately. No avg_vld after release until the next trigger.
- Strobe arithmetic: mode[0]=1, smpl ch0=0x400, strobe at n -> avg_out ch0=0x100 and avg_vld[0] in n+2. A second strobe gives acc=0x700, avg_out=0x1C0.
- Seed: seed[1] with smpl ch1=0xABC -> avg_out ch1=0xABC two cycles later. A subsequent strobe with the same sample keeps 0xABC.
- Round-robin: strobe[3:0]=4'hF in cycle n, all mode=1 -> avg_vld pulses ch0,ch1,ch2,ch3 in cycles n+2..n+5, one per cycle.
- Periodic tick: all mode=0, samples 0x100 -> first update of all four channels 65536 clocks after reset, avg_out=0x040.
- Overrun (macro on): strobe ch0..ch2 in n, strobe ch2 again in n+1 -> overrun[2]=1 and ch2 updated once; ovr_clr -> 0. Macro off: overrun stays 0.
